// File: rtl/ctrl_seq.sv
// ctrl_seq: sequences one instruction through READ -> EXEC -> WRITE -> DONE,
// skipping disabled phases; each phase is a one-cycle strobe.
// Ports: clk, rst_n (async, active-low); instr/instr_valid/instr_ready
// handshake; data_bus, addr1, opcode, flag_register registered fields;
// read, opcode_enable, write phase strobes; busy, done status.
// Option: define CTRL_SEQ_PREFETCH_EN for a one-entry prefetch buffer.
module ctrl_seq #(
  parameter int DW  = 16,
  parameter int AW  = 5,
  parameter int OPW = 4,
  parameter int FW  = 4,
  localparam int IW = DW + AW + 3 + OPW + FW
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [IW-1:0]  instr,
  input  logic           instr_valid,
  output logic           instr_ready,
  output logic [DW-1:0]  data_bus,
  output logic [AW-1:0]  addr1,
  output logic [OPW-1:0] opcode,
  output logic [FW-1:0]  flag_register,
  output logic           read,
  output logic           opcode_enable,
  output logic           write,
  output logic           busy,
  output logic           done
);

  // bit position of e; w and r sit directly above it
  localparam int EB = FW + OPW;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_EXEC  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } st_t;

  st_t r_state;
  st_t w_next;

  logic [DW-1:0]  r_data;
  logic [AW-1:0]  r_addr;
  logic [OPW-1:0] r_op;
  logic [FW-1:0]  r_flag;
  logic           r_w;
  logic           r_e;

  logic           w_xfer;
  logic           w_load_new;
  logic           w_load_buf;
  logic           w_ready;
  logic [IW-1:0]  w_src;

  function automatic st_t first_st(logic r, logic w, logic e);
    st_t s;
    if (r)      s = S_READ;
    else if (e) s = S_EXEC;
    else if (w) s = S_WRITE;
    else        s = S_DONE;
    return s;
  endfunction

  assign w_xfer = instr_valid & w_ready;

`ifdef CTRL_SEQ_PREFETCH_EN
  logic [IW-1:0] r_buf;
  logic          r_buf_vld;
  logic          w_fill;

  // A word taken in DONE with an empty buffer goes straight to the
  // field registers, so the buffer is never left full on entry to IDLE.
  assign w_ready    = (r_state == S_IDLE) | ~r_buf_vld;
  assign w_load_buf = (r_state == S_DONE) & r_buf_vld;
  assign w_load_new = w_xfer &
                      ((r_state == S_IDLE) |
                       ((r_state == S_DONE) & ~r_buf_vld));
  assign w_fill     = w_xfer & ~w_load_new;
  assign w_src      = w_load_buf ? r_buf : instr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf     <= '0;
      r_buf_vld <= 1'b0;
    end else if (w_fill) begin
      r_buf     <= instr;
      r_buf_vld <= 1'b1;
    end else if (w_load_buf) begin
      r_buf_vld <= 1'b0;
    end
  end
`else
  assign w_ready    = (r_state == S_IDLE);
  assign w_load_buf = 1'b0;
  assign w_load_new = w_xfer;
  assign w_src      = instr;
`endif

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // field registers load only when a new instruction starts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_addr <= '0;
      r_op   <= '0;
      r_flag <= '0;
      r_w    <= 1'b0;
      r_e    <= 1'b0;
    end else if (w_load_new | w_load_buf) begin
      r_data <= w_src[IW-1 -: DW];
      r_addr <= w_src[EB+3 +: AW];
      r_w    <= w_src[EB+1];
      r_e    <= w_src[EB];
      r_op   <= w_src[FW +: OPW];
      r_flag <= w_src[FW-1:0];
    end
  end

  // next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_load_new)
          w_next = first_st(w_src[EB+2], w_src[EB+1], w_src[EB]);
      end
      S_READ: begin
        if (r_e)      w_next = S_EXEC;
        else if (r_w) w_next = S_WRITE;
        else          w_next = S_DONE;
      end
      S_EXEC: begin
        if (r_w) w_next = S_WRITE;
        else     w_next = S_DONE;
      end
      S_WRITE: w_next = S_DONE;
      S_DONE: begin
        if (w_load_new | w_load_buf)
          w_next = first_st(w_src[EB+2], w_src[EB+1], w_src[EB]);
        else
          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // outputs
  always_comb begin
    instr_ready   = w_ready;
    read          = (r_state == S_READ);
    opcode_enable = (r_state == S_EXEC);
    write         = (r_state == S_WRITE);
    done          = (r_state == S_DONE);
    busy          = (r_state != S_IDLE);
    data_bus      = r_data;
    addr1         = r_addr;
    opcode        = r_op;
    flag_register = r_flag;
  end

endmodule

// File: tb/tb_ctrl_seq.sv
// tb_ctrl_seq: self-checking bench for ctrl_seq (default parameters),
// directed scenarios plus a random run against a phase-queue model.
module tb_ctrl_seq;

`ifdef CTRL_SEQ_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] data_bus;
  logic [4:0]  addr1;
  logic [3:0]  opcode;
  logic [3:0]  flag_register;
  logic        read;
  logic        opcode_enable;
  logic        write;
  logic        busy;
  logic        done;

  int tests = 0;
  int fails = 0;

  ctrl_seq dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .data_bus      (data_bus),
    .addr1         (addr1),
    .opcode        (opcode),
    .flag_register (flag_register),
    .read          (read),
    .opcode_enable (opcode_enable),
    .write         (write),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  // {ready, busy, done, write, opcode_enable, read}
  function automatic logic [5:0] ctl();
    return {instr_ready, busy, done, write, opcode_enable, read};
  endfunction

  // fields in instruction layout with r/w/e zeroed
  function automatic logic [31:0] fld();
    return {data_bus, addr1, 3'b000, opcode, flag_register};
  endfunction

  function automatic logic [31:0] mk(logic [15:0] d, logic [4:0] a,
                                     logic r, logic w, logic e,
                                     logic [3:0] op, logic [3:0] fl);
    return {d, a, r, w, e, op, fl};
  endfunction

  // directed-run capture
  logic [31:0] sq[$];
  int          acc[$];
  logic [5:0]  tr[0:15];
  logic [31:0] tf[0:15];

  task automatic run(input int n);
    logic rdy;
    acc.delete();
    for (int k = 1; k <= n; k++) begin
      if (sq.size() > 0) begin
        instr = sq[0];
        instr_valid = 1'b1;
      end else begin
        instr_valid = 1'b0;
      end
      rdy = instr_ready;
      @(posedge clk);
      if (instr_valid && rdy) begin
        acc.push_back(k - 1);
        void'(sq.pop_front());
      end
      #1;
      tr[k] = ctl();
      tf[k] = fld();
    end
    instr_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    instr_valid = 1'b0;
    instr = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (ctl() !== 6'b100000 || fld() !== 32'h0) begin
      fails++;
      $display("FAIL reset_state ctl=%b fld=%h want 100000/0", ctl(), fld());
    end
    @(posedge clk); #1;
    tests++;
    if (ctl() !== 6'b100000) begin
      fails++;
      $display("FAIL reset_idle ctl=%b want 100000", ctl());
    end
  endtask

  task automatic test_all_phase();
    logic [31:0] w;
    logic [5:0]  exp[1:5];
    w = 32'hABCD_0000 | mk(16'h0, 5'd7, 1, 1, 1, 4'h5, 4'h3);
    exp[1] = {PF, 5'b10001};
    exp[2] = {PF, 5'b10010};
    exp[3] = {PF, 5'b10100};
    exp[4] = {PF, 5'b11000};
    exp[5] = 6'b100000;
    sq.delete();
    sq.push_back(w);
    run(5);
    for (int k = 1; k <= 5; k++) begin
      tests++;
      if (tr[k] !== exp[k]) begin
        fails++;
        $display("FAIL all_phase_T+%0d ctl=%b want %b", k, tr[k], exp[k]);
      end
    end
    tests++;
    if (data_bus !== 16'hABCD || addr1 !== 5'd7 ||
        opcode !== 4'h5 || flag_register !== 4'h3) begin
      fails++;
      $display("FAIL all_phase_fields got %h/%0d/%h/%h want abcd/7/5/3",
               data_bus, addr1, opcode, flag_register);
    end
  endtask

  task automatic test_read_only();
    sq.delete();
    sq.push_back(mk(16'h1234, 5'd3, 1, 0, 0, 4'h9, 4'hA));
    run(3);
    tests++;
    if (tr[1] !== {PF, 5'b10001} || tr[2] !== {PF, 5'b11000} ||
        tr[3] !== 6'b100000) begin
      fails++;
      $display("FAIL read_only ctl=%b,%b,%b", tr[1], tr[2], tr[3]);
    end
    sq.push_back(mk(16'h5A5A, 5'd31, 0, 0, 0, 4'hF, 4'h1));
    run(2);
    tests++;
    if (tr[1] !== {PF, 5'b11000} || tr[2] !== 6'b100000 ||
        tf[1] !== 32'h5A5A_F8F1) begin
      fails++;
      $display("FAIL no_phase ctl=%b,%b fld=%h", tr[1], tr[2], tf[1]);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    logic [31:0] b;
    int          ea;
    int          eb;
    int          d1;
    int          d2;
    a = mk(16'h1111, 5'd1, 1, 1, 1, 4'h1, 4'h1);
    b = mk(16'h2222, 5'd2, 1, 1, 1, 4'h2, 4'h2);
    eb = PF ? 1 : 5;
    d1 = 4;
    d2 = PF ? 8 : 9;
    sq.delete();
    sq.push_back(a);
    sq.push_back(b);
    run(11);
    tests++;
    if (acc.size() != 2 || acc[0] != 0 || acc[1] != eb) begin
      fails++;
      $display("FAIL b2b_accept n=%0d second=%0d want %0d",
               acc.size(), acc.size() > 1 ? acc[1] : -1, eb);
    end
    ea = PF ? 0 : 1;
    for (int k = 1; k <= 10; k++) begin
      tests++;
      if (tr[k][3] !== ((k == d1) || (k == d2))) begin
        fails++;
        $display("FAIL b2b_done_T+%0d done=%b", k, tr[k][3]);
      end
    end
    tests++;
    if (tf[d1] !== (a & ~32'h700) || tf[d1 + 1 + ea] !== (b & ~32'h700) ||
        tr[d1 + 1 + ea][0] !== 1'b1) begin
      fails++;
      $display("FAIL b2b_switch fld=%h,%h ctl=%b",
               tf[d1], tf[d1 + 1 + ea], tr[d1 + 1 + ea]);
    end
    if (!PF) begin
      tests++;
      if (tr[2][5] !== 1'b0 || tr[4][5] !== 1'b0 || tr[5] !== 6'b100000) begin
        fails++;
        $display("FAIL hold_off ctl=%b,%b,%b", tr[2], tr[4], tr[5]);
      end
    end
  endtask

  task automatic test_reset_mid_exec();
    bit bad;
    sq.delete();
    sq.push_back(mk(16'hBEEF, 5'd9, 1, 1, 1, 4'h6, 4'h7));
    run(2);
    tests++;
    if (tr[2][1] !== 1'b1) begin
      fails++;
      $display("FAIL rst_setup ctl=%b want exec", tr[2]);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (ctl() !== 6'b100000 || fld() !== 32'h0) begin
      fails++;
      $display("FAIL rst_mid_exec ctl=%b fld=%h", ctl(), fld());
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    bad = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (done || busy) bad = 1'b1;
    end
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL rst_no_resume busy/done seen after release");
    end
  endtask

  // model: queue of per-cycle phase entries; front = current cycle
  typedef struct {
    logic [3:0]  ph;   // {done, write, opcode_enable, read}
    int          id;
    logic [31:0] f;
  } ent_t;

  ent_t mq[$];

  task automatic m_push(input logic [31:0] x, input int id);
    ent_t e;
    e.id = id;
    e.f  = x & ~32'h700;
    if (x[10]) begin e.ph = 4'b0001; mq.push_back(e); end
    if (x[8])  begin e.ph = 4'b0010; mq.push_back(e); end
    if (x[9])  begin e.ph = 4'b0100; mq.push_back(e); end
    e.ph = 4'b1000;
    mq.push_back(e);
  endtask

  function automatic logic m_ready();
    if (mq.size() == 0) return 1'b1;
    if (!PF) return 1'b0;
    return mq[0].id == mq[mq.size() - 1].id;
  endfunction

  task automatic test_random();
    logic        er;
    logic [31:0] ef;
    logic [5:0]  ec;
    logic [3:0]  ph;
    int          nid;
    do_reset();
    mq.delete();
    ef = '0;
    nid = 0;
    for (int c = 0; c < 400; c++) begin
      instr_valid = ($urandom_range(0, 2) != 0);
      instr = $urandom;
      er = m_ready();
      @(posedge clk);
      if (mq.size() > 0) void'(mq.pop_front());
      if (instr_valid && er) begin
        m_push(instr, nid);
        nid++;
      end
      if (mq.size() > 0) ef = mq[0].f;
      ph = (mq.size() > 0) ? mq[0].ph : 4'b0000;
      ec = {m_ready(), mq.size() > 0, ph};
      #1;
      tests++;
      if (ctl() !== ec) begin
        fails++;
        $display("FAIL rand_ctl cyc=%0d got %b want %b", c, ctl(), ec);
      end
      tests++;
      if (fld() !== ef) begin
        fails++;
        $display("FAIL rand_fld cyc=%0d got %h want %h", c, fld(), ef);
      end
    end
    instr_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    instr_valid = 1'b0;
    instr = '0;
    test_reset();
    test_all_phase();
    test_read_only();
    test_back_to_back();
    test_reset_mid_exec();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
